host_tag_arbiter: RTL

Shares the 10-bit PCIe packet tag space (packet_tag_t) among NUM_REQ host-side requesters of the AXI-S host datapath. Keeps a FIFO free list of tags, grants tags round-robin and records the owner of each outstanding tag. On completion it frees the tag and reports which requester owns it.

---
 rtl/host_tag_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/host_tag_arbiter.sv
// host_tag_arbiter: shares the packet tag space among NUM_REQ host-side requesters.
// A FIFO free list is loaded with tags 0..NUM_TAGS-1 after reset. Grants are issued
// round-robin, one per cycle, and the owner of each outstanding tag is recorded.
// Releases push the tag back and report its owner.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req              per-requester level request
//   gnt, gnt_tag     one-hot grant pulse and the tag issued with it
//   rel_valid/tag    completion frees rel_tag
//   rel_owner_valid  pulse for an accepted release; rel_owner = owner of that tag
//   free_count       tags currently in the free list
//   init_done        free list loaded, grants enabled
//   err_double_free  sticky flag for a release of a tag not in use (or out of range)
//
// Optional: define HOST_TAG_ARBITER_HALT_EN to add halt_req/halt_ack. While halt_req
// is high no grants are issued; halt_ack reports that every tag has come home.
module host_tag_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_WIDTH = 10,
  parameter int unsigned NUM_TAGS  = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [TAG_WIDTH-1:0]       gnt_tag,
  input  logic                       rel_valid,
  input  logic [TAG_WIDTH-1:0]       rel_tag,
  output logic                       rel_owner_valid,
  output logic [$clog2(NUM_REQ)-1:0] rel_owner,
  output logic [TAG_WIDTH:0]         free_count,
  output logic                       init_done,
  output logic                       err_double_free
`ifdef HOST_TAG_ARBITER_HALT_EN
  ,
  input  logic                       halt_req,
  output logic                       halt_ack
`endif
);

  localparam int unsigned OwnW  = $clog2(NUM_REQ);
  localparam int unsigned AddrW = $clog2(NUM_TAGS);
  localparam logic [TAG_WIDTH:0] LastPtr = (TAG_WIDTH+1)'(NUM_TAGS - 1);
  localparam logic [TAG_WIDTH:0] AllFree = (TAG_WIDTH+1)'(NUM_TAGS);
  localparam logic [OwnW-1:0]    LastReq = OwnW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               state_q;
  logic [TAG_WIDTH:0]   wr_ptr_q, rd_ptr_q;
  logic [NUM_TAGS-1:0]  in_use_q;
  logic [OwnW-1:0]      owner_q [NUM_TAGS];
  logic [OwnW-1:0]      rr_ptr_q;
  logic [TAG_WIDTH-1:0] fifo_mem [NUM_TAGS];

  logic [TAG_WIDTH-1:0] head_tag;
  logic [AddrW-1:0]     head_idx, rel_idx;
  logic                 rel_ok, rel_bad, grant_ok, grant_block, push;
  logic [TAG_WIDTH-1:0] push_tag;
  logic                 win_found;
  logic [OwnW-1:0]      win_idx;
  logic [TAG_WIDTH:0]   free_d;

  function automatic logic [TAG_WIDTH:0] ptr_inc(input logic [TAG_WIDTH:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign head_tag = fifo_mem[rd_ptr_q[AddrW-1:0]];
  assign head_idx = head_tag[AddrW-1:0];
  assign rel_idx  = rel_tag[AddrW-1:0];

  // Out-of-range tags are rejected before the bitmap lookup is trusted.
  assign rel_ok  = (state_q == StRun) && rel_valid && (32'(rel_tag) < NUM_TAGS) &&
                   in_use_q[rel_idx];
  assign rel_bad = (state_q == StRun) && rel_valid && !rel_ok;

`ifdef HOST_TAG_ARBITER_HALT_EN
  assign grant_block = halt_req;
`else
  assign grant_block = 1'b0;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      if (!win_found && req[(32'(rr_ptr_q) + 32'(i)) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = OwnW'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
      end
    end
  end

  assign grant_ok = (state_q == StRun) && win_found && (free_count != '0) && !grant_block;

  // During init the write pointer doubles as the tag counter.
  assign push     = (state_q == StInit) || rel_ok;
  assign push_tag = (state_q == StInit) ? wr_ptr_q[TAG_WIDTH-1:0] : rel_tag;

  always_comb begin
    free_d = free_count;
    if (push && !grant_ok) begin
      free_d = free_count + 1'b1;
    end else if (!push && grant_ok) begin
      free_d = free_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AddrW-1:0]] <= push_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StInit;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      in_use_q        <= '0;
      rr_ptr_q        <= LastReq;
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        owner_q[i] <= '0;
      end
      gnt             <= '0;
      gnt_tag         <= '0;
      rel_owner_valid <= 1'b0;
      rel_owner       <= '0;
      free_count      <= '0;
      init_done       <= 1'b0;
      err_double_free <= 1'b0;
`ifdef HOST_TAG_ARBITER_HALT_EN
      halt_ack        <= 1'b0;
`endif
    end else begin
      gnt             <= '0;
      rel_owner_valid <= 1'b0;
      init_done       <= (state_q == StRun);
      free_count      <= free_d;

      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end

      case (state_q)
        StInit: if (wr_ptr_q == LastPtr) state_q <= StRun;
        StRun:  state_q <= StRun;
        default: state_q <= StInit;
      endcase

      if (grant_ok) begin
        gnt[win_idx]       <= 1'b1;
        gnt_tag            <= head_tag;
        rd_ptr_q           <= ptr_inc(rd_ptr_q);
        in_use_q[head_idx] <= 1'b1;
        owner_q[head_idx]  <= win_idx;
        rr_ptr_q           <= win_idx;
      end

      // A granted tag becomes in-use only after this edge, so it never equals rel_idx.
      if (rel_ok) begin
        in_use_q[rel_idx] <= 1'b0;
        rel_owner_valid   <= 1'b1;
        rel_owner         <= owner_q[rel_idx];
      end

      if (rel_bad) begin
        err_double_free <= 1'b1;
      end

`ifdef HOST_TAG_ARBITER_HALT_EN
      halt_ack <= halt_req && (state_q == StRun) && (free_count == AllFree);
`endif
    end
  end

endmodule
